// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide unit.
// Op encodings, FSM states and the magnitude helper.
package mdu_pkg;

  localparam int WIDTH_C = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic [WIDTH_C-1:0] mag(
    input logic [WIDTH_C-1:0] v,
    input logic               neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Sequencer for the multiply/divide unit.
// Owns the IDLE/RUN/FIX state and the 5-bit iteration counter.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic skip,
  output logic accept,
  output logic step,
  output logic fix,
  output logic busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          cnt_d  = ITER_LAST;
          // divide-by-zero goes straight to completion
          state_d = skip ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
        else cnt_d = cnt_q - 1'b1;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit.
// Shift-add multiply and restoring divide on magnitudes, sign fix at end.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_C
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  logic accept, step, fix, skip;
  logic is_div_q, sa_q, sb_q, dz_q;
  logic sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] acc_hi, acc_lo, b_q;
  logic [WIDTH:0]   msum, dsh;
  logic             dge;
  logic [2*WIDTH-1:0] acc_step, prod, res;
  logic [WIDTH-1:0] q_res, r_res;

  assign skip   = op[1] & (B == '0);
  assign sgn_op = ~op[0];
  assign a_neg  = sgn_op & A[WIDTH-1] & ~skip;
  assign b_neg  = sgn_op & B[WIDTH-1] & ~skip;

  mdu_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (reset_n),
    .start  (start),
    .skip   (skip),
    .accept (accept),
    .step   (step),
    .fix    (fix),
    .busy   (busy)
  );

  always_comb begin
    msum = {1'b0, acc_hi} + {1'b0, b_q};
    dsh  = {acc_hi, acc_lo[WIDTH-1]};
    dge  = (dsh >= {1'b0, b_q});
    if (is_div_q) begin
      if (dge) acc_step = {dsh[WIDTH-1:0] - b_q, acc_lo[WIDTH-2:0], 1'b1};
      else     acc_step = {dsh[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_lo[0]) acc_step = {msum, acc_lo[WIDTH-1:1]};
      else           acc_step = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end
    prod  = {acc_hi, acc_lo};
    q_res = (sa_q ^ sb_q) ? -acc_lo : acc_lo;
    r_res = sa_q ? -acc_hi : acc_hi;
    if (is_div_q) res = {r_res, q_res};
    else          res = (sa_q ^ sb_q) ? -prod : prod;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_q      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        is_div_q <= op[1];
        sa_q     <= a_neg;
        sb_q     <= b_neg;
        dz_q     <= skip;
        b_q      <= mag(B, b_neg);
        // divide-by-zero preloads its fixed result: hi=A, lo=all ones
        if (skip) begin
          acc_hi <= A;
          acc_lo <= '1;
        end else begin
          acc_hi   <= '0;
          acc_lo   <= mag(A, a_neg);
          div_zero <= 1'b0;
        end
      end
      if (step) {acc_hi, acc_lo} <= acc_step;
      if (fix) begin
        {hi, lo} <= res;
        done     <= 1'b1;
        div_zero <= dz_q;
      end
    end
  end

endmodule
